// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Field positions match the decoder's view of an instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 25;
  localparam int FUNCT_LSB = 20;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 12;

  localparam int PC_STEP        = 4;
  localparam int PC_READ_OFFSET = 8;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer holding {instr, pc} pairs.
// Flush wins over push; push and pop may coincide at any occupancy.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [PW:0]   cnt_q;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (!push && pop) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  // storage write; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake,
// fetch buffer and pre-sliced decoder fields.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus8,
  output logic [3:0]         cond,
  output logic [1:0]         op,
  output logic [5:0]         funct,
  output logic [3:0]         rd
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + ADDR_W;

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] drain_q;
  logic [ADDR_W-1:0] tgt;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [EW-1:0]     head_v;
  logic              unused_ok;

  assign tgt = {branch_target[ADDR_W-1:2], 2'b00};

  assign imem_req  = ~reset & (state_q != HOLD);
  assign imem_addr = (state_q == DRAIN) ? drain_q : pc_q;

  assign pop  = instr_valid & ~stall & ~branch_taken;
  assign push = (state_q == FETCH) & imem_ack & ~branch_taken;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .wdata ({imem_rdata, pc_q}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // fetch FSM with PC and squashed-address registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= {RESET_PC[ADDR_W-1:2], 2'b00};
      drain_q <= '0;
    end else if (branch_taken) begin
      pc_q <= tgt;
      if (state_q == FETCH && !imem_ack) begin
        state_q <= DRAIN;
        drain_q <= pc_q;
      end else if (state_q == DRAIN && !imem_ack) begin
        state_q <= DRAIN;
      end else begin
        state_q <= FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_q <= pc_q + ADDR_W'(PC_STEP);
            if (count == CW'(DEPTH - 1) && !pop)
              state_q <= HOLD;
          end
        end
        HOLD: begin
          if (pop) state_q <= FETCH;
        end
        DRAIN: begin
          if (imem_ack) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign instr_valid = ~empty;
  assign head_v      = instr_valid ? head : '0;
  assign instr       = head_v[EW-1:ADDR_W];
  assign instr_pc    = head_v[ADDR_W-1:0];
  assign pc_plus8    = instr_valid ?
                       instr_pc + ADDR_W'(PC_READ_OFFSET) : '0;

  assign cond  = instr[COND_MSB:COND_LSB];
  assign op    = instr[OP_MSB:OP_LSB];
  assign funct = instr[FUNCT_MSB:FUNCT_LSB];
  assign rd    = instr[RD_MSB:RD_LSB];

  assign unused_ok = ^{branch_target[1:0], full};

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic
// checked against a queue-based transaction model.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus8      (pc_plus8),
    .cond          (cond),
    .op            (op),
    .funct         (funct),
    .rd            (rd)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  logic [31:0] daddr;
  bit          drain;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ovr;
  bit          use_ovr = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc   = 32'h0;
    daddr = 32'h0;
    drain = 0;
  endtask

  task automatic step(input bit st, input bit ak, input bit br,
                      input logic [31:0] tg);
    bit          rq;
    bit          a;
    bit          pp;
    logic [31:0] ad;
    ent_t        h;
    @(negedge clk);
    rq = drain || (q.size() < DEPTH);
    ad = drain ? daddr : mpc;
    a  = ak & rq;
    stall         = st;
    imem_ack      = a;
    branch_taken  = br;
    branch_target = tg;
    if (use_ovr && a && !drain && !br) begin
      imem_rdata = ovr;
      use_ovr    = 0;
    end else begin
      imem_rdata = a ? memw(ad) : $urandom;
    end
    #1;
    chk("req", {31'b0, imem_req}, {31'b0, rq});
    if (rq) chk("addr", imem_addr, ad);
    chk("valid", {31'b0, instr_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      h = q[0];
      chk("instr", instr, h.w);
      chk("instr_pc", instr_pc, h.pc);
      chk("pc_plus8", pc_plus8, h.pc + 32'd8);
      chk("cond", {28'b0, cond}, {28'b0, h.w[31:28]});
      chk("op", {30'b0, op}, {30'b0, h.w[27:26]});
      chk("funct", {26'b0, funct}, {26'b0, h.w[25:20]});
      chk("rd", {28'b0, rd}, {28'b0, h.w[15:12]});
    end
    @(posedge clk);
    pp = (q.size() > 0) && !st && !br;
    if (br) begin
      if (rq && !a && !drain) begin
        drain = 1;
        daddr = mpc;
      end else if (drain && a) begin
        drain = 0;
      end
      q.delete();
      mpc = {tg[31:2], 2'b00};
    end else begin
      if (pp) void'(q.pop_front());
      if (drain) begin
        if (a) drain = 0;
      end else if (a) begin
        q.push_back({imem_rdata, mpc});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_pc8", pc_plus8, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    #11 reset = 1'b0;

    ovr     = 32'hE281_1001;
    use_ovr = 1;
    step(0, 1, 0, 0);
    #1;
    chk("t2_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_instr", instr, 32'hE281_1001);
    chk("t2_cond", {28'b0, cond}, 32'hE);
    chk("t2_op", {30'b0, op}, 32'h0);
    chk("t2_funct", {26'b0, funct}, 32'h28);
    chk("t2_rd", {28'b0, rd}, 32'h1);
    chk("t2_pc8", pc_plus8, 32'h8);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    #1;
    chk("t3_hold_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

    step(0, 0, 1, 32'h100);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    #1;
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    step(0, 1, 1, 32'h43);
    #1;
    chk("t5_valid", {31'b0, instr_valid}, 32'd0);
    chk("t5_addr", imem_addr, 32'h40);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    step(0, 0, 1, 32'h200);
    step(0, 0, 0, 0);
    @(negedge clk);
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_valid", {31'b0, instr_valid}, 32'd0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    step(0, 1, 1, 32'hFFFF_FFFB);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg;
      if ($urandom_range(0, 3) == 0)
        tg = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else
        tg = $urandom & 32'h3FF;
      step($urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) == 0,
           tg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
